// File: rtl/serial_bus_arbiter_nxm.sv
// N-master x M-slave serial bus arbiter with slave-ID decode and single split resume.
// Optional idle-connection timeout is compiled in when ARB_TIMEOUT_EN is defined.
module serial_bus_arbiter_nxm #(
    parameter int                    NUM_MASTERS    = 2,
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    SEL_BITS       = $clog2(NUM_SLAVES),
    parameter int                    PRIORITY_MODE  = 0,
    parameter logic [NUM_SLAVES-1:0] SPLIT_MASK     = '1,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_breq,
    output logic [NUM_MASTERS-1:0] m_bgrant,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_wr_bus,
    input  logic [NUM_MASTERS-1:0] m_master_valid,
    input  logic [NUM_MASTERS-1:0] m_master_ready,
    output logic [NUM_MASTERS-1:0] m_rd_bus,
    output logic [NUM_MASTERS-1:0] m_slave_ready,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic [NUM_MASTERS-1:0] m_ack,
    output logic [NUM_MASTERS-1:0] m_nack,
    output logic [NUM_MASTERS-1:0] m_split,
    output logic [NUM_MASTERS-1:0] m_timeout,
    output logic [NUM_SLAVES-1:0]  s_mode,
    output logic [NUM_SLAVES-1:0]  s_wr_bus,
    output logic [NUM_SLAVES-1:0]  s_master_valid,
    output logic [NUM_SLAVES-1:0]  s_master_ready,
    input  logic [NUM_SLAVES-1:0]  s_rd_bus,
    input  logic [NUM_SLAVES-1:0]  s_slave_ready,
    input  logic [NUM_SLAVES-1:0]  s_slave_valid,
    input  logic [NUM_SLAVES-1:0]  s_split
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(SEL_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, CONNECTED, SPLIT, RESUME, NACK, CLEAN
    } state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          owner_q, owner_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          split_owner_q, split_owner_d;
    logic [SEL_BITS-1:0]    sel_q, sel_d;
    logic [SEL_BITS-1:0]    split_slave_q, split_slave_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   ack_q, ack_d;
    logic                   split_pend_q, split_pend_d;

    logic [NUM_MASTERS-1:0] elig;
    logic [MW-1:0]          win;
    logic                   found;
    logic [SEL_BITS-1:0]    sel_nx;
    logic                   to_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          idle;
`endif

    // The split-parked master never competes until its slave releases it.
    always_comb begin : p_arb
        int idx;
        elig = m_breq;
        if (split_pend_q) elig[split_owner_q] = 1'b0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        if (PRIORITY_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (elig[MW'(i)]) begin
                    found = 1'b1;
                    win   = MW'(i);
                end
            end
        end else begin
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
                if (!found && elig[MW'(idx)]) begin
                    found = 1'b1;
                    win   = MW'(idx);
                end
            end
        end
    end

    always_comb begin : p_next
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        split_owner_d = split_owner_q;
        split_slave_d = split_slave_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        ack_d         = 1'b0;
        split_pend_d  = split_pend_q;
        sel_nx        = (sel_q << 1) | SEL_BITS'(m_wr_bus[owner_q]);
        to_hit        = 1'b0;
`ifdef ARB_TIMEOUT_EN
        idle_cnt_d = '0;
        idle = !s_slave_ready[sel_q] && !s_slave_valid[sel_q]
            && !m_master_valid[owner_q];
        if (state_q == CONNECTED && idle
            && idle_cnt_q == TW'(TIMEOUT_CYCLES - 1))
            to_hit = 1'b1;
`endif
        unique case (state_q)
            IDLE: begin
                if (split_pend_q && !s_split[split_slave_q]) begin
                    state_d = RESUME;
                    owner_d = split_owner_q;
                    sel_d   = split_slave_q;
                    grant_d = '0;
                    grant_d[split_owner_q] = 1'b1;
                end else if (found) begin
                    state_d = ADDR;
                    owner_d = win;
                    sel_d   = '0;
                    cnt_d   = '0;
                    grant_d = '0;
                    grant_d[win] = 1'b1;
                    if (PRIORITY_MODE == 0) rr_ptr_d = win;
                end
            end
            ADDR: begin
                if (!m_breq[owner_q]) begin
                    state_d = CLEAN;
                    grant_d = '0;
                end else if (m_master_valid[owner_q]) begin
                    sel_d = sel_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SEL_BITS - 1)) begin
                        if (int'(sel_nx) < NUM_SLAVES
                            && !(split_pend_q && sel_nx == split_slave_q)) begin
                            state_d = CONNECTED;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = NACK;
                            grant_d = '0;
                        end
                    end
                end
            end
            CONNECTED: begin
`ifdef ARB_TIMEOUT_EN
                idle_cnt_d = idle ? idle_cnt_q + TW'(1) : '0;
`endif
                if (!m_breq[owner_q] || to_hit) begin
                    state_d = CLEAN;
                    grant_d = '0;
                end else if (s_split[sel_q] && SPLIT_MASK[sel_q]
                             && !split_pend_q) begin
                    state_d       = SPLIT;
                    grant_d       = '0;
                    split_pend_d  = 1'b1;
                    split_owner_d = owner_q;
                    split_slave_d = sel_q;
                end
            end
            SPLIT: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
            RESUME: begin
                split_pend_d = 1'b0;
                if (!m_breq[owner_q]) begin
                    state_d = CLEAN;
                    grant_d = '0;
                end else begin
                    state_d = CONNECTED;
                    ack_d   = 1'b1;
                end
            end
            NACK: state_d = CLEAN;
            CLEAN: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : p_route
        s_mode         = '0;
        s_wr_bus       = '0;
        s_master_valid = '0;
        s_master_ready = '0;
        m_rd_bus       = '0;
        m_slave_ready  = '0;
        m_slave_valid  = '0;
        m_ack          = '0;
        m_nack         = '0;
        m_split        = '0;
        m_timeout      = '0;
        m_ack[owner_q] = ack_q;
        if (split_pend_q && state_q != RESUME) m_split[split_owner_q] = 1'b1;
        if (state_q == ADDR) m_slave_ready[owner_q] = 1'b1;
        if (state_q == NACK) m_nack[owner_q] = 1'b1;
        if (state_q == CONNECTED) begin
            s_mode[sel_q]          = m_mode[owner_q];
            s_wr_bus[sel_q]        = m_wr_bus[owner_q];
            s_master_valid[sel_q]  = m_master_valid[owner_q];
            s_master_ready[sel_q]  = m_master_ready[owner_q];
            m_rd_bus[owner_q]      = s_rd_bus[sel_q];
            m_slave_ready[owner_q] = s_slave_ready[sel_q];
            m_slave_valid[owner_q] = s_slave_valid[sel_q];
            m_timeout[owner_q]     = to_hit;
        end
    end

    assign m_bgrant = grant_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= MW'(NUM_MASTERS - 1);
            split_owner_q <= '0;
            split_slave_q <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            ack_q         <= 1'b0;
            split_pend_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            split_owner_q <= split_owner_d;
            split_slave_q <= split_slave_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            ack_q         <= ack_d;
            split_pend_q  <= split_pend_d;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_bus_arbiter_nxm.sv
// Directed bench for serial_bus_arbiter_nxm: 3 masters, 3 slaves, round-robin,
// plus a fixed-priority instance; timeout checks follow ARB_TIMEOUT_EN.
module tb_serial_bus_arbiter_nxm;
    localparam int NM = 3;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [NM-1:0] m_breq, m_bgrant, m_mode, m_wr_bus, m_master_valid;
    logic [NM-1:0] m_master_ready, m_rd_bus, m_slave_ready, m_slave_valid;
    logic [NM-1:0] m_ack, m_nack, m_split, m_timeout;
    logic [NS-1:0] s_mode, s_wr_bus, s_master_valid, s_master_ready;
    logic [NS-1:0] s_rd_bus, s_slave_ready, s_slave_valid, s_split;

    logic [NM-1:0] fx_breq, fx_bgrant, fx_rd_bus, fx_slave_ready;
    logic [NM-1:0] fx_slave_valid, fx_ack, fx_nack, fx_split, fx_timeout;
    logic [NS-1:0] fx_s_mode, fx_s_wr_bus, fx_s_mvalid, fx_s_mready;

    serial_bus_arbiter_nxm #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS),
        .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_breq(m_breq), .m_bgrant(m_bgrant), .m_mode(m_mode),
        .m_wr_bus(m_wr_bus), .m_master_valid(m_master_valid),
        .m_master_ready(m_master_ready), .m_rd_bus(m_rd_bus),
        .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid),
        .m_ack(m_ack), .m_nack(m_nack), .m_split(m_split),
        .m_timeout(m_timeout), .s_mode(s_mode), .s_wr_bus(s_wr_bus),
        .s_master_valid(s_master_valid), .s_master_ready(s_master_ready),
        .s_rd_bus(s_rd_bus), .s_slave_ready(s_slave_ready),
        .s_slave_valid(s_slave_valid), .s_split(s_split)
    );

    serial_bus_arbiter_nxm #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS),
        .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)
    ) dut_fx (
        .clk(clk), .rstn(rstn),
        .m_breq(fx_breq), .m_bgrant(fx_bgrant), .m_mode(3'b000),
        .m_wr_bus(3'b000), .m_master_valid(3'b000),
        .m_master_ready(3'b000), .m_rd_bus(fx_rd_bus),
        .m_slave_ready(fx_slave_ready), .m_slave_valid(fx_slave_valid),
        .m_ack(fx_ack), .m_nack(fx_nack), .m_split(fx_split),
        .m_timeout(fx_timeout), .s_mode(fx_s_mode), .s_wr_bus(fx_s_wr_bus),
        .s_master_valid(fx_s_mvalid), .s_master_ready(fx_s_mready),
        .s_rd_bus(3'b000), .s_slave_ready(3'b000),
        .s_slave_valid(3'b000), .s_split(3'b000)
    );

    typedef struct {
        logic [2:0] breq, mval, mwr, ssplit, srdy;
        logic [2:0] grant, ack, nack, split, msrdy, smval, swr;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic [2:0] breq, mval, mwr, ssplit, srdy,
                       grant, ack, nack, split, msrdy, smval, swr);
        vec_t v;
        v = '{breq, mval, mwr, ssplit, srdy,
              grant, ack, nack, split, msrdy, smval, swr};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        chk({name, ".m"}, {m_bgrant, m_rd_bus, m_slave_ready, m_slave_valid,
            m_ack, m_nack, m_split, m_timeout}, 64'h0);
        chk({name, ".s"}, {s_mode, s_wr_bus, s_master_valid, s_master_ready},
            64'h0);
        chk({name, ".fx"}, {fx_bgrant, fx_rd_bus, fx_slave_ready,
            fx_slave_valid, fx_ack, fx_nack, fx_split, fx_timeout, fx_s_mode,
            fx_s_wr_bus, fx_s_mvalid, fx_s_mready}, 64'h0);
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rstn = 1'b0;
        m_breq = '0; m_mode = '0; m_wr_bus = '0; m_master_valid = '0;
        m_master_ready = '0; s_rd_bus = '0; s_slave_ready = '0;
        s_slave_valid = '0; s_split = '0; fx_breq = '0;
        repeat (2) step();
        check_zero("reset");
        rstn = 1'b1;

        // breq  mval   mwr    ssplit srdy | grant  ack    nack   split  msrdy  smval  swr
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b001,3'b000,3'b000,3'b000,3'b001,3'b000,3'b000);
        add(3'b110,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b010,3'b000,3'b000,3'b000,3'b010,3'b000,3'b000);
        add(3'b111,3'b010,3'b010,3'b000,3'b000, 3'b010,3'b000,3'b000,3'b000,3'b010,3'b000,3'b000);
        add(3'b111,3'b010,3'b000,3'b000,3'b000, 3'b010,3'b010,3'b000,3'b000,3'b000,3'b100,3'b000);
        add(3'b111,3'b010,3'b010,3'b000,3'b100, 3'b010,3'b000,3'b000,3'b000,3'b010,3'b100,3'b100);
        add(3'b111,3'b000,3'b010,3'b000,3'b000, 3'b010,3'b000,3'b000,3'b000,3'b000,3'b000,3'b100);
        add(3'b101,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b100,3'b000,3'b000,3'b000,3'b100,3'b000,3'b000);
        add(3'b011,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b001,3'b000,3'b000,3'b000,3'b001,3'b000,3'b000);
        add(3'b111,3'b001,3'b001,3'b000,3'b000, 3'b001,3'b000,3'b000,3'b000,3'b001,3'b000,3'b000);
        add(3'b111,3'b001,3'b001,3'b000,3'b000, 3'b000,3'b000,3'b001,3'b000,3'b000,3'b000,3'b000);
        add(3'b111,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b001,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b001,3'b000,3'b000,3'b000,3'b000, 3'b001,3'b000,3'b000,3'b000,3'b001,3'b000,3'b000);
        add(3'b001,3'b001,3'b000,3'b000,3'b000, 3'b001,3'b000,3'b000,3'b000,3'b001,3'b000,3'b000);
        add(3'b001,3'b001,3'b001,3'b000,3'b000, 3'b001,3'b001,3'b000,3'b000,3'b000,3'b010,3'b010);
        add(3'b011,3'b000,3'b000,3'b010,3'b000, 3'b000,3'b000,3'b000,3'b001,3'b000,3'b000,3'b000);
        add(3'b011,3'b000,3'b000,3'b010,3'b000, 3'b000,3'b000,3'b000,3'b001,3'b000,3'b000,3'b000);
        add(3'b011,3'b000,3'b000,3'b010,3'b000, 3'b010,3'b000,3'b000,3'b001,3'b010,3'b000,3'b000);
        add(3'b011,3'b010,3'b000,3'b010,3'b000, 3'b010,3'b000,3'b000,3'b001,3'b010,3'b000,3'b000);
        add(3'b011,3'b010,3'b010,3'b010,3'b000, 3'b000,3'b000,3'b010,3'b001,3'b000,3'b000,3'b000);
        add(3'b001,3'b000,3'b000,3'b010,3'b000, 3'b000,3'b000,3'b000,3'b001,3'b000,3'b000,3'b000);
        add(3'b001,3'b000,3'b000,3'b010,3'b000, 3'b000,3'b000,3'b000,3'b001,3'b000,3'b000,3'b000);
        add(3'b001,3'b000,3'b000,3'b010,3'b000, 3'b000,3'b000,3'b000,3'b001,3'b000,3'b000,3'b000);
        add(3'b001,3'b000,3'b000,3'b000,3'b000, 3'b001,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b001,3'b001,3'b001,3'b000,3'b000, 3'b001,3'b001,3'b000,3'b000,3'b000,3'b010,3'b010);
        add(3'b000,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);
        add(3'b000,3'b000,3'b000,3'b000,3'b000, 3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000);

        foreach (vq[i]) begin
            m_breq = vq[i].breq;
            m_master_valid = vq[i].mval;
            m_wr_bus = vq[i].mwr;
            s_split = vq[i].ssplit;
            s_slave_ready = vq[i].srdy;
            step();
            chk($sformatf("v%0d.grant", i), m_bgrant, vq[i].grant);
            chk($sformatf("v%0d.ack", i), m_ack, vq[i].ack);
            chk($sformatf("v%0d.nack", i), m_nack, vq[i].nack);
            chk($sformatf("v%0d.split", i), m_split, vq[i].split);
            chk($sformatf("v%0d.msrdy", i), m_slave_ready, vq[i].msrdy);
            chk($sformatf("v%0d.smval", i), s_master_valid, vq[i].smval);
            chk($sformatf("v%0d.swr", i), s_wr_bus, vq[i].swr);
            chk($sformatf("v%0d.quiet", i), {m_timeout, s_mode,
                s_master_ready, m_rd_bus, m_slave_valid}, 64'h0);
        end

        // M2 -> slave 0: routing of mode/ready/read data both ways
        m_breq = 3'b100;
        step();
        chk("rt.grant", m_bgrant, 3'b100);
        m_master_valid = 3'b100;
        m_wr_bus = 3'b000;
        step();
        step();
        chk("rt.ack", m_ack, 3'b100);
        chk("rt.smval", s_master_valid, 3'b001);
        m_master_valid = 3'b000;
        m_mode = 3'b100;
        m_master_ready = 3'b100;
        s_rd_bus = 3'b001;
        s_slave_valid = 3'b001;
        #1;
        chk("rt.smode", s_mode, 3'b001);
        chk("rt.smrdy", s_master_ready, 3'b001);
        chk("rt.mrd", m_rd_bus, 3'b100);
        chk("rt.msval", m_slave_valid, 3'b100);
        chk("rt.smval0", s_master_valid, 3'b000);
        s_rd_bus = 3'b110;
        s_slave_valid = 3'b110;
        s_slave_ready = 3'b110;
        #1;
        chk("rt.other", {m_rd_bus, m_slave_valid, m_slave_ready}, 9'h0);
        m_mode = '0; m_master_ready = '0;
        s_rd_bus = '0; s_slave_valid = '0; s_slave_ready = '0;

        // split M2 on slave 0, connect M0 to slave 2, then reset mid-transfer
        s_split = 3'b001;
        step();
        chk("rs.split", m_split, 3'b100);
        chk("rs.grant0", m_bgrant, 3'b000);
        m_breq = 3'b101;
        step();
        step();
        chk("rs.grant", m_bgrant, 3'b001);
        chk("rs.split2", m_split, 3'b100);
        m_master_valid = 3'b001;
        m_wr_bus = 3'b001;
        step();
        m_wr_bus = 3'b000;
        step();
        chk("rs.ack", m_ack, 3'b001);
        chk("rs.smval", s_master_valid, 3'b100);
        rstn = 1'b0;
        step();
        check_zero("rs.reset");
        rstn = 1'b1;
        m_breq = 3'b111;
        s_split = 3'b000;
        m_master_valid = 3'b000;
        step();
        chk("rs.regrant", m_bgrant, 3'b001);
        chk("rs.nosplit", m_split, 3'b000);
        m_breq = 3'b000;
        step();
        step();

        // M1 -> slave 1 with a silent slave
        m_breq = 3'b010;
        step();
        chk("to.grant", m_bgrant, 3'b010);
        m_master_valid = 3'b010;
        m_wr_bus = 3'b000;
        step();
        m_wr_bus = 3'b010;
        step();
        chk("to.ack", m_ack, 3'b010);
        m_master_valid = 3'b000;
        m_wr_bus = 3'b000;
        #1;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("to.k%0d", k), m_timeout,
                (k == 8) ? 3'b010 : 3'b000);
            if (k < 8) step();
        end
        step();
        chk("to.clean", m_bgrant, 3'b000);
        chk("to.pulse", m_timeout, 3'b000);
`else
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("to.k%0d", k), m_timeout, 3'b000);
            step();
        end
        chk("to.held", m_bgrant, 3'b010);
`endif
        m_breq = 3'b000;
        repeat (3) step();

        // fixed priority: lowest index wins regardless of history
        fx_breq = 3'b110;
        step();
        chk("fx.grant1", fx_bgrant, 3'b010);
        fx_breq = 3'b101;
        step();
        chk("fx.clean", fx_bgrant, 3'b000);
        step();
        step();
        chk("fx.grant0", fx_bgrant, 3'b001);
        chk("fx.srdy", fx_slave_ready, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
